// File: rtl/ar_fifo_pkg.sv
// Shared definitions for the ar_* FIFO family: count-width helper,
// flag reset values and default almost-full/almost-empty thresholds.
package ar_fifo_pkg;

    // Default thresholds: AFULL at depth - DEF_AFULL_MARGIN, AEMPTY at DEF_AEMPTY_LVL
    localparam int unsigned DEF_AFULL_MARGIN = 2;
    localparam int unsigned DEF_AEMPTY_LVL   = 2;

    // Flag values held while in reset / clear
    localparam logic FULL_N_RST  = 1'b1;
    localparam logic EMPTY_N_RST = 1'b0;
    localparam logic STICKY_RST  = 1'b0;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int unsigned clog2p1(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ar_srl_fifo_lvl_if.sv
// Handshake/data bundle for ar_srl_fifo_lvl. The master drives requests and
// write data; the slave (the FIFO) returns head data, flags and occupancy.
interface ar_srl_fifo_lvl_if
    import ar_fifo_pkg::*;
#(
    parameter int unsigned width   = 32,
    parameter int unsigned l2depth = 4
);
    logic                                 CLR;
    logic                                 ENQ;
    logic                                 DEQ;
    logic [width-1:0]                     D_IN;
    logic [width-1:0]                     D_OUT;
    logic                                 FULL_N;
    logic                                 EMPTY_N;
    logic                                 AFULL;
    logic                                 AEMPTY;
    logic [clog2p1(2**l2depth)-1:0]       COUNT;
    logic                                 OVF;
    logic                                 UNF;

    modport master (
        output CLR, ENQ, DEQ, D_IN,
        input  D_OUT, FULL_N, EMPTY_N, AFULL, AEMPTY, COUNT, OVF, UNF
    );

    modport slave (
        input  CLR, ENQ, DEQ, D_IN,
        output D_OUT, FULL_N, EMPTY_N, AFULL, AEMPTY, COUNT, OVF, UNF
    );
endinterface

// File: rtl/ar_srl_shift.sv
// Reset-free shift array with an addressed read port; written so the storage
// maps onto SRL primitives. New words enter at index 0.
module ar_srl_shift
    import ar_fifo_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned depth = 16
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic [width-1:0]         i_d,
    input  logic [$clog2(depth)-1:0] i_addr,
    output logic [width-1:0]         o_q
);
    logic [width-1:0] r_dat [depth];

    // Shift in a new word; no reset so the array stays SRL-inferable
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_dat[0] <= i_d;
            for (int unsigned i = 1; i < depth; i++) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_q = r_dat[i_addr];
endmodule

// File: rtl/ar_srl_fifo_lvl.sv
// SRL-based synchronous FIFO with occupancy count, almost-full/almost-empty
// flags and sticky overflow/underflow flags.
// Build option ARSRL_FIFO_OREG_EN: adds an output register (obuf/ov) in front
// of D_OUT/EMPTY_N; capacity becomes depth+1 and COUNT excludes obuf.
module ar_srl_fifo_lvl
    import ar_fifo_pkg::*;
#(
    parameter int unsigned width      = 32,
    parameter int unsigned l2depth    = 4,
    parameter int unsigned afull_lvl  = (2**l2depth) - DEF_AFULL_MARGIN,
    parameter int unsigned aempty_lvl = DEF_AEMPTY_LVL
) (
    input  logic               CLK,
    input  logic               RST_N,
    ar_srl_fifo_lvl_if.slave   fifo
);
    localparam int unsigned DEPTH = 2**l2depth;
    localparam int unsigned CW    = clog2p1(DEPTH);

    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic               r_unf;
    logic               w_full_n;
    logic               w_srl_nempty;
    logic               w_empty_n;
    logic               w_enq_ok;
    logic               w_deq_ok;
    logic               w_pop;
    logic [width-1:0]   w_head;
    logic [l2depth-1:0] w_rd_addr;

    assign w_full_n     = (r_count != CW'(DEPTH));
    assign w_srl_nempty = (r_count != '0);
    assign w_rd_addr    = l2depth'(r_count - 1'b1);
    assign w_enq_ok     = fifo.ENQ & w_full_n & ~fifo.CLR;

    ar_srl_shift #(
        .width (width),
        .depth (DEPTH)
    ) u_shift (
        .i_clk  (CLK),
        .i_en   (w_enq_ok),
        .i_d    (fifo.D_IN),
        .i_addr (w_rd_addr),
        .o_q    (w_head)
    );

`ifdef ARSRL_FIFO_OREG_EN
    logic               r_ov;
    logic [width-1:0]   r_obuf;

    // The SRL is popped by refilling obuf, not by the consumer directly
    assign w_empty_n = r_ov;
    assign w_deq_ok  = fifo.DEQ & r_ov & ~fifo.CLR;
    assign w_pop     = (~r_ov | w_deq_ok) & w_srl_nempty & ~fifo.CLR;

    // Output-register valid bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)        r_ov <= EMPTY_N_RST;
        else if (fifo.CLR) r_ov <= EMPTY_N_RST;
        else if (w_pop)    r_ov <= 1'b1;
        else if (w_deq_ok) r_ov <= 1'b0;
    end

    // Output-register data; no reset, only meaningful while r_ov is set
    always_ff @(posedge CLK) begin
        if (w_pop) r_obuf <= w_head;
    end

    assign fifo.D_OUT = r_obuf;
`else
    assign w_empty_n  = w_srl_nempty;
    assign w_deq_ok   = fifo.DEQ & w_srl_nempty & ~fifo.CLR;
    assign w_pop      = w_deq_ok;
    assign fifo.D_OUT = w_head;
`endif

    // Occupancy: +1 on push only, -1 on pop only, otherwise hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (fifo.CLR) begin
            r_count <= '0;
        end else begin
            case ({w_enq_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags for refused requests
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ovf <= STICKY_RST;
            r_unf <= STICKY_RST;
        end else if (fifo.CLR) begin
            r_ovf <= STICKY_RST;
            r_unf <= STICKY_RST;
        end else begin
            if (fifo.ENQ & ~w_full_n)  r_ovf <= 1'b1;
            if (fifo.DEQ & ~w_empty_n) r_unf <= 1'b1;
        end
    end

    assign fifo.FULL_N  = w_full_n;
    assign fifo.EMPTY_N = w_empty_n;
    assign fifo.AFULL   = (32'(r_count) >= afull_lvl);
    assign fifo.AEMPTY  = (32'(r_count) <= aempty_lvl);
    assign fifo.COUNT   = r_count;
    assign fifo.OVF     = r_ovf;
    assign fifo.UNF     = r_unf;
endmodule

// File: doc/ar_srl_fifo_lvl.md
# ar_srl_fifo_lvl

Parametrised SRL-based synchronous FIFO with guarded handshakes, occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It is the next-generation small FIFO for worker datapaths: it absorbs clock-aligned rate mismatch between adjacent pipeline stages and gives upstream logic early back-pressure.

## Interface
- width, 32: data word width in bits (≥1)
- l2depth, 4: log2 of SRL depth; depth = 2**l2depth (2..6)
- afull_lvl, depth-2: AFULL asserts when COUNT ≥ afull_lvl
- aempty_lvl, 2: AEMPTY asserts when COUNT ≤ aempty_lvl
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CLR  in  1  synchronous clear; same effect as reset
- ENQ  in  1  enqueue request; D_IN captured when accepted
- DEQ  in  1  dequeue request; head word consumed when accepted
- D_IN  in  width  write data
- D_OUT  out  width  head-of-queue data; valid only while EMPTY_N=1
- FULL_N  out  1  1 = space available
- EMPTY_N  out  1  1 = D_OUT holds valid data
- AFULL  out  1  almost-full
- AEMPTY  out  1  almost-empty
- COUNT  out  l2depth+1  SRL occupancy, 0..depth
- OVF  out  1  sticky: ENQ attempted while FULL_N=0
- UNF  out  1  sticky: DEQ attempted while EMPTY_N=0

## Operation
- Accept rules: enq_ok = ENQ & FULL_N; deq_ok = DEQ & EMPTY_N. Refused requests leave state unchanged.
- Storage: shift register dat[0..depth-1]; on enq_ok, dat[i] <= dat[i-1] and dat[0] <= D_IN. The array is not reset; its update sits in its own always block with no reset term, to preserve SRL inference.
- Count: enq_ok only → +1; deq_ok only → −1; both or neither → hold. Head read address is COUNT−1.
- Flags are decoded from registered COUNT: FULL_N = (COUNT≠depth), EMPTY_N = (COUNT≠0), AFULL = (COUNT≥afull_lvl), AEMPTY = (COUNT≤aempty_lvl).
- OVF is set on ENQ & !FULL_N; UNF is set on DEQ & !EMPTY_N. Both hold until reset or CLR.
- Simultaneous ENQ and DEQ:
  - When full: only the dequeue is accepted, COUNT → depth−1, OVF is set.
  - When empty: only the enqueue is accepted, COUNT → 1, UNF is set.
  - Otherwise both are accepted and COUNT holds.
- Reset or CLR values: COUNT=0, FULL_N=1, EMPTY_N=0, AFULL=(afull_lvl==0), AEMPTY=1, OVF=0, UNF=0. D_OUT is undefined.
- CLR has priority over ENQ/DEQ in the same cycle; that cycle's requests are dropped.
- Asserting RST_N low mid-transfer clears state immediately, regardless of CLK. Deassertion is synchronised externally.

## Timing
- No combinational path from ENQ, DEQ or D_IN to any output.
- Without the output register, an enqueue into an empty FIFO gives EMPTY_N=1 on the next cycle, and D_OUT shows the word in that same cycle.
- FULL_N falls the cycle after the depth-th accepted enqueue.
- Sustained ENQ and DEQ every cycle gives full throughput with COUNT constant.

## Configuration
- Macro: ARSRL_FIFO_OREG_EN.
- When defined: D_OUT and EMPTY_N come from an output register obuf with valid bit ov.
  - obuf loads from the SRL head when (!ov | deq_ok) and COUNT≠0. That load decrements COUNT.
  - EMPTY_N = ov.
  - First-word latency becomes 2 cycles.
  - Total capacity is depth+1. COUNT excludes obuf.
  - Reset/CLR clears ov; obuf data is not reset.
- When undefined: D_OUT = dat[COUNT−1], EMPTY_N = (COUNT≠0), with latency and capacity as above.

## Structure
- A shared package ar_fifo_pkg holds the count-width function clog2p1(depth), the flag-decode constants, and default threshold values.
- One sub-module, ar_srl_shift, holds the reset-free shift array plus the read mux (width, depth). The control/flag logic lives in the top module.

## Test plan
All scenarios use width=8, l2depth=3 (depth 8), afull_lvl=6, aempty_lvl=2.
- Reset: drop RST_N with no clock edge → COUNT=0, EMPTY_N=0, FULL_N=1, AEMPTY=1, OVF=UNF=0 immediately.
- Fill and drain: enqueue 0x01..0x08.
  - FULL_N=0 after the 8th; AFULL rises when COUNT=6.
  - Dequeue 8 → D_OUT reads 0x01..0x08 in order; EMPTY_N=0 after the last.
- Overflow: with the FIFO full, ENQ=1, D_IN=0xAA → COUNT stays 8, OVF=1 and stays set. A later dequeue never returns 0xAA.
- Underflow: with the FIFO empty, DEQ=1 → UNF=1, COUNT=0. ENQ=1 and DEQ=1 while empty → COUNT=1, D_OUT=D_IN.
- Simultaneous at full: ENQ=DEQ=1 → COUNT=7, head advances, OVF=1. At COUNT=4 with ENQ=DEQ=1 for 20 cycles → COUNT stays 4 and order is preserved.
- CLR with ARSRL_FIFO_OREG_EN defined:
  - CLR at COUNT=5 → all flags at reset values next cycle.
  - After one enqueue, EMPTY_N=1 two cycles later.
  - Capacity check: 9 words are accepted before FULL_N=0.
